// File: rtl/cva6_ptw_sv32_refill_pkg.sv
// Sv32 page-table walker types, constants and the PTE address helper.
package cva6_ptw_sv32_refill_pkg;
   localparam int unsigned PT_LEVELS_SV32 = 2;
   localparam int unsigned PTESIZE_SV32   = 4;
   localparam int unsigned PLEN_SV32      = 34;
   localparam int unsigned ASID_W_SV32    = 1;

   typedef struct packed {
      logic [21:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_sv32_t;

   typedef struct packed {
      logic                   valid;
      logic                   is_4M;
      logic [19:0]            vpn;
      logic [ASID_W_SV32-1:0] asid;
      pte_sv32_t              content;
   } tlb_update_sv32_t;

   typedef enum logic [2:0] {
      IDLE, MEM_REQ, WAIT_RVALID, PTE_CHECK, FLUSH_DRAIN
   } ptw_sv32_state_e;

   // Table base plus index scaled by the PTE size; wraps silently at 34 bits.
   function automatic logic [PLEN_SV32-1:0] pte_addr(logic [21:0] ppn, logic [9:0] vpn);
      return {ppn, 12'b0} + PLEN_SV32'(vpn) * PLEN_SV32'(PTESIZE_SV32);
   endfunction
endpackage

// File: rtl/cva6_ptw_sv32_refill_if.sv
// Single-port PTE read bus: one request/grant, then one rvalid beat.
interface cva6_ptw_sv32_refill_if;
   import cva6_ptw_sv32_refill_pkg::*;
   logic                 req;
   logic [PLEN_SV32-1:0] addr;
   logic                 gnt;
   logic                 rvalid;
   logic [31:0]          rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/cva6_ptw_sv32_refill.sv
// Sv32 two-level walker: refills the shared TLB on a lookup miss or reports a page fault.
module cva6_ptw_sv32_refill
   import cva6_ptw_sv32_refill_pkg::*;
#(
   parameter int unsigned ASID_WIDTH = ASID_W_SV32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic [21:0]            satp_ppn_i,
   input  logic [ASID_WIDTH-1:0]  asid_i,
   input  logic                   shared_tlb_access_i,
   input  logic                   shared_tlb_hit_i,
   input  logic [31:0]            shared_tlb_vaddr_i,
   input  logic                   itlb_req_i,
   cva6_ptw_sv32_refill_if.master mem,
   output tlb_update_sv32_t       shared_tlb_update_o,
   output logic                   walking_o,
   output logic                   ptw_error_o,
   output logic                   ptw_error_itlb_o,
   output logic [31:0]            bad_vaddr_o
);
   ptw_sv32_state_e      state_q, state_d;
   logic [31:0]          vaddr_q;
   logic                 itlb_q;
   logic [ASID_WIDTH-1:0] asid_q;
   logic                 level_q;
   logic                 global_q;
   logic [PLEN_SV32-1:0] addr_q;
   pte_sv32_t            pte_q;
   logic                 leaf, fault;

   // Legality of a fetched PTE at the given level; a pointer at level 0 is illegal too.
   function automatic logic pte_fault(pte_sv32_t pte, logic lvl);
      logic is_leaf;
      is_leaf = pte.r | pte.x;
      if (!pte.v || (!pte.r && pte.w)) return 1'b1;
      if (is_leaf && !pte.a)           return 1'b1;
      if (is_leaf && lvl && (pte.ppn[9:0] != 10'd0)) return 1'b1;
      if (!is_leaf && !lvl)            return 1'b1;
      return 1'b0;
   endfunction

   assign leaf  = pte_q.r | pte_q.x;
   assign fault = pte_fault(pte_q, level_q);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Walk context: captured at miss, PTE latched on rvalid, descend on a level-1 pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vaddr_q  <= '0;
         itlb_q   <= 1'b0;
         asid_q   <= '0;
         level_q  <= 1'b0;
         global_q <= 1'b0;
         addr_q   <= '0;
         pte_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (shared_tlb_access_i && !shared_tlb_hit_i && !flush_i) begin
               vaddr_q  <= shared_tlb_vaddr_i;
               itlb_q   <= itlb_req_i;
               asid_q   <= asid_i;
               level_q  <= 1'(PT_LEVELS_SV32 - 1);
               global_q <= 1'b0;
               addr_q   <= pte_addr(satp_ppn_i, shared_tlb_vaddr_i[31:22]);
            end
            WAIT_RVALID: if (mem.rvalid && !flush_i) pte_q <= pte_sv32_t'(mem.rdata);
            PTE_CHECK: if (!flush_i && !fault && !leaf) begin
               level_q  <= 1'b0;
               addr_q   <= pte_addr(pte_q.ppn, vaddr_q[21:12]);
               global_q <= pte_q.g;
            end
            default: ;
         endcase
      end
   end

   // Next state; a granted-then-flushed read must still be drained.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:        if (shared_tlb_access_i && !shared_tlb_hit_i && !flush_i) state_d = MEM_REQ;
         MEM_REQ:     if (flush_i)        state_d = mem.gnt ? FLUSH_DRAIN : IDLE;
                      else if (mem.gnt)   state_d = WAIT_RVALID;
         WAIT_RVALID: if (flush_i)        state_d = mem.rvalid ? IDLE : FLUSH_DRAIN;
                      else if (mem.rvalid) state_d = PTE_CHECK;
         PTE_CHECK:   state_d = (flush_i || fault || leaf) ? IDLE : MEM_REQ;
         FLUSH_DRAIN: if (mem.rvalid)     state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Outputs: request while in MEM_REQ, single-cycle update or fault out of PTE_CHECK.
   always_comb begin
      mem.req             = 1'b0;
      mem.addr            = '0;
      shared_tlb_update_o = '0;
      ptw_error_o         = 1'b0;
      ptw_error_itlb_o    = 1'b0;
      bad_vaddr_o         = '0;
      walking_o           = (state_q != IDLE);
      unique case (state_q)
         MEM_REQ: begin
            mem.req  = 1'b1;
            mem.addr = addr_q;
         end
         PTE_CHECK: if (!flush_i) begin
            if (fault) begin
               ptw_error_o      = 1'b1;
               ptw_error_itlb_o = itlb_q;
               bad_vaddr_o      = vaddr_q;
            end else if (leaf) begin
               shared_tlb_update_o.valid     = 1'b1;
               shared_tlb_update_o.is_4M     = level_q;
               shared_tlb_update_o.vpn       = vaddr_q[31:12];
               shared_tlb_update_o.asid      = ASID_W_SV32'(asid_q);
               shared_tlb_update_o.content   = pte_q;
               shared_tlb_update_o.content.g = pte_q.g | global_q;
            end
         end
         default: ;
      endcase
   end
endmodule
